// File: rtl/tetris_pkg.sv
// tetris_pkg: piece codes, piece width and piece_queue state encodings shared across the game.
package tetris_pkg;
    localparam int PIECE_W = 2;
    localparam logic [PIECE_W-1:0] PIECE_I = 2'd0;
    localparam logic [PIECE_W-1:0] PIECE_O = 2'd1;
    localparam logic [PIECE_W-1:0] PIECE_T = 2'd2;
    localparam logic [PIECE_W-1:0] PIECE_L = 2'd3;
    typedef enum logic [1:0] {
        S_WARM = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;
endpackage

// File: rtl/piece_queue_if.sv
// piece_queue_if: RNG sample input, valid/take handshake and preview/status outputs of piece_queue.
interface piece_queue_if #(
    parameter int DEPTH = 4,
    parameter int PIECE_W = 2
);
    logic [PIECE_W-1:0] random;
    logic rand_valid;
    logic piece_take;
    logic [PIECE_W-1:0] piece_out;
    logic piece_valid;
    logic [PIECE_W-1:0] preview_out;
    logic preview_valid;
    logic [$clog2(DEPTH):0] count;
    logic full;
    logic underflow;
    modport master (
        output random, rand_valid, piece_take,
        input piece_out, piece_valid, preview_out, preview_valid, count, full, underflow
    );
    modport slave (
        input random, rand_valid, piece_take,
        output piece_out, piece_valid, preview_out, preview_valid, count, full, underflow
    );
endinterface

// File: rtl/piece_fifo_mem.sv
// piece_fifo_mem: unreset piece storage, one write port and head/head+1 read ports.
module piece_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int PIECE_W = 2
) (
    input  logic clka,
    input  logic we,
    input  logic [$clog2(DEPTH)-1:0] wa,
    input  logic [PIECE_W-1:0] wd,
    input  logic [$clog2(DEPTH)-1:0] ra,
    output logic [PIECE_W-1:0] rd0,
    output logic [PIECE_W-1:0] rd1
);
    logic [PIECE_W-1:0] mem [DEPTH];
    always_ff @(posedge clka)
        if (we) mem[wa] <= wd;
    assign rd0 = mem[ra];
    assign rd1 = mem[ra + 1'b1];
endmodule

// File: rtl/piece_queue.sv
// piece_queue: preview FIFO between the RNG and game control with registered head/preview outputs.
// Define NO_REPEAT_EN to bump a push that repeats the previously stored piece.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PIECE_W = tetris_pkg::PIECE_W
) (
    input logic clka,
    input logic restart,
    piece_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    state_t state, state_n;
    logic push, pop, uf;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PIECE_W-1:0] wdata, head_m, prev_m, head_n, prev_n, head_q, prev_q;

    always_ff @(posedge clka or posedge restart)
        if (restart) state <= S_WARM;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_WARM: state_n = S_FILL;
            S_FILL: state_n = (push && !pop && cnt == CW'(DEPTH - 1)) ? S_FULL : S_FILL;
            S_FULL: state_n = (pop && !push) ? S_FILL : S_FULL;
            default: state_n = S_WARM;
        endcase
    end

    // When full, a sample is accepted only alongside a pop freeing its slot.
    always_comb begin
        push = q.rand_valid && (state == S_FILL || (state == S_FULL && q.piece_take));
        pop = q.piece_take && cnt != '0;
    end

`ifdef NO_REPEAT_EN
    logic [PIECE_W-1:0] last_pushed;
    logic last_valid;
    always_ff @(posedge clka or posedge restart)
        if (restart) begin
            last_pushed <= '0;
            last_valid <= 1'b0;
        end else if (push) begin
            last_pushed <= wdata;
            last_valid <= 1'b1;
        end
    assign wdata = (last_valid && q.random == last_pushed) ? q.random + 1'b1 : q.random;
`else
    assign wdata = q.random;
`endif

    piece_fifo_mem #(.DEPTH(DEPTH), .PIECE_W(PIECE_W)) u_mem (
        .clka(clka), .we(push), .wa(wr_ptr), .wd(wdata),
        .ra(rd_n), .rd0(head_m), .rd1(prev_m)
    );

    // Look ahead at the post-edge pointers, bypassing the slot written this cycle.
    always_comb begin
        rd_n = rd_ptr + AW'(pop);
        cnt_n = cnt + CW'(push) - CW'(pop);
        head_n = (cnt_n == '0) ? '0 : (push && wr_ptr == rd_n) ? wdata : head_m;
        prev_n = (cnt_n < CW'(2)) ? '0 : (push && wr_ptr == rd_n + 1'b1) ? wdata : prev_m;
    end

    always_ff @(posedge clka or posedge restart)
        if (restart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            head_q <= '0;
            prev_q <= '0;
            uf <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_n;
            cnt <= cnt_n;
            head_q <= head_n;
            prev_q <= prev_n;
            uf <= uf | (q.piece_take && cnt == '0);
        end

    assign q.piece_out = head_q;
    assign q.preview_out = prev_q;
    assign q.piece_valid = cnt != '0;
    assign q.preview_valid = cnt >= CW'(2);
    assign q.count = cnt;
    assign q.full = cnt == CW'(DEPTH);
    assign q.underflow = uf;
endmodule

// File: tb/tb_piece_queue.sv
// tb_piece_queue: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_piece_queue;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic restart = 1'b1;
    int checks = 0;
    int errors = 0;
    int mq[$];
    bit m_warm;
    bit m_uf;
    int m_last;
    bit m_lv;
    logic [10:0] act;

    piece_queue_if #(.DEPTH(DEPTH), .PIECE_W(2)) qi ();
    piece_queue #(.DEPTH(DEPTH), .PIECE_W(2)) dut (.clka(clk), .restart(restart), .q(qi));

    always #5 clk = ~clk;

    assign act = {qi.piece_out, qi.piece_valid, qi.preview_out, qi.preview_valid,
                  qi.count, qi.full, qi.underflow};

    function automatic logic [10:0] exp_vec();
        logic [1:0] h, p;
        int n;
        n = mq.size();
        h = (n > 0) ? 2'(mq[0]) : 2'd0;
        p = (n > 1) ? 2'(mq[1]) : 2'd0;
        return {h, n > 0, p, n > 1, 3'(n), n == DEPTH, m_uf};
    endfunction

    task automatic do_reset();
        qi.random = 2'd0;
        qi.rand_valid = 1'b0;
        qi.piece_take = 1'b0;
        restart = 1'b1;
        #3;
        restart = 1'b0;
        mq.delete();
        m_warm = 1'b1;
        m_uf = 1'b0;
        m_last = 0;
        m_lv = 1'b0;
    endtask

    task automatic step(input bit rv, input logic [1:0] rnd, input bit take);
        bit pu, po;
        int v;
        qi.rand_valid = rv;
        qi.random = rnd;
        qi.piece_take = take;
        @(posedge clk);
        po = take && mq.size() > 0;
        pu = !m_warm && rv && (mq.size() < DEPTH || po);
        if (take && mq.size() == 0) m_uf = 1'b1;
        v = int'(rnd);
`ifdef NO_REPEAT_EN
        if (pu) begin
            if (m_lv && v == m_last) v = (v + 1) % 4;
            m_last = v;
            m_lv = 1'b1;
        end
`endif
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back(v);
        m_warm = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (act !== 11'd0) begin
            errors++;
            $display("FAIL reset act=%h exp=%h", act, 11'd0);
        end
    endtask

    task automatic test_warmup();
        do_reset();
        step(1, 2'd2, 0);
        checks++;
        if (act !== exp_vec() || qi.count !== 3'd0) begin
            errors++;
            $display("FAIL warm_edge1 act=%h exp=%h", act, exp_vec());
        end
        step(1, 2'd2, 0);
        checks++;
        if (act !== exp_vec() || qi.count !== 3'd1 || qi.piece_out !== 2'd2 || qi.piece_valid !== 1'b1) begin
            errors++;
            $display("FAIL warm_edge2 act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_fill_full();
        int vals[4] = '{1, 3, 0, 2};
        do_reset();
        step(0, 2'd0, 0);
        foreach (vals[i]) step(1, 2'(vals[i]), 0);
        checks++;
        if (act !== exp_vec() || qi.count !== 3'd4 || qi.full !== 1'b1 || qi.piece_out !== 2'd1 || qi.preview_out !== 2'd3) begin
            errors++;
            $display("FAIL fill_full act=%h exp=%h", act, exp_vec());
        end
        step(1, 2'd1, 0);
        checks++;
        if (act !== exp_vec() || qi.count !== 3'd4) begin
            errors++;
            $display("FAIL full_ignore act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_wrap();
        int pushv[6] = '{0, 1, 2, 3, 0, 1};
        int outv[6] = '{1, 3, 0, 2, 0, 1};
        foreach (pushv[i]) begin
            checks++;
            if (qi.piece_out !== 2'(outv[i])) begin
                errors++;
                $display("FAIL wrap_head_%0d act=%0d exp=%0d", i, qi.piece_out, outv[i]);
            end
            step(1, 2'(pushv[i]), 1);
            checks++;
            if (act !== exp_vec() || qi.count !== 3'd4) begin
                errors++;
                $display("FAIL wrap_state_%0d act=%h exp=%h", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_simul_one();
        do_reset();
        step(0, 2'd0, 0);
        step(1, 2'd2, 0);
        step(1, 2'd3, 1);
        checks++;
        if (act !== exp_vec() || qi.piece_out !== 2'd3 || qi.count !== 3'd1 || qi.preview_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_one act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_underflow_async();
        do_reset();
        step(0, 2'd0, 0);
        step(0, 2'd0, 1);
        checks++;
        if (act !== exp_vec() || qi.underflow !== 1'b1 || qi.count !== 3'd0) begin
            errors++;
            $display("FAIL underflow act=%h exp=%h", act, exp_vec());
        end
        step(1, 2'd1, 0);
        step(1, 2'd2, 0);
        checks++;
        if (act !== exp_vec()) begin
            errors++;
            $display("FAIL underflow_sticky act=%h exp=%h", act, exp_vec());
        end
        #2;
        restart = 1'b1;
        #1;
        checks++;
        if (act !== 11'd0) begin
            errors++;
            $display("FAIL async_reset act=%h exp=%h", act, 11'd0);
        end
    endtask

    task automatic test_no_repeat();
        int exp_seq[3];
`ifdef NO_REPEAT_EN
        exp_seq = '{2, 3, 0};
`else
        exp_seq = '{2, 2, 3};
`endif
        do_reset();
        step(0, 2'd0, 0);
        step(1, 2'd2, 0);
        step(1, 2'd2, 0);
        step(1, 2'd3, 0);
        foreach (exp_seq[i]) begin
            checks++;
            if (qi.piece_out !== 2'(exp_seq[i]) || act !== exp_vec()) begin
                errors++;
                $display("FAIL no_repeat_%0d act=%0d exp=%0d", i, qi.piece_out, exp_seq[i]);
            end
            step(0, 2'd0, 1);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 70, 2'($urandom_range(3)), $urandom_range(99) < 40);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                bad++;
                if (bad <= 10) $display("FAIL random_%0d act=%h exp=%h", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_fill_full();
        test_wrap();
        test_simul_one();
        test_underflow_async();
        test_no_repeat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
